// File: rtl/search_fanout_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : search_fanout_pkg
//  Purpose  : Shared defaults, stage record and operand-combine function for
//             the search fanout pipeline.
//  Revision : 1.0 - initial release
// ============================================================================
package search_fanout_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_STAGES = 3;
    localparam int DEF_N_CH   = 3;
    localparam int DEF_CNT_W  = 8;

    // Layout of one pipeline stage at the default width; wider or narrower
    // instances declare the same {valid, data} shape locally.
    typedef struct packed {
        logic                 valid;
        logic [DEF_WIDTH-1:0] data;
    } stage_rec_t;

    // Bitwise combine of the four operands; applied per bit so it is
    // independent of the operand width.
    function automatic logic combine(input logic a, input logic b,
                                     input logic c, input logic d,
                                     input logic invert);
        logic r;
        r = (a & b) & (c | d);
        return invert ? ~r : r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/search_fanout_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module   : search_fanout_pipe_if
//  Purpose  : Operand handshake, per-channel output handshake and status
//             counters of the search fanout pipeline.
//  Revision : 1.0 - initial release
// ============================================================================
interface search_fanout_pipe_if
    import search_fanout_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N_CH  = DEF_N_CH,
    parameter int CNT_W = DEF_CNT_W
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      in1;
    logic [WIDTH-1:0]      in2;
    logic [WIDTH-1:0]      in3;
    logic [WIDTH-1:0]      in4;
    logic [N_CH-1:0]       ch_en;
    logic [N_CH-1:0]       out_valid;
    logic [N_CH-1:0]       out_ready;
    logic [N_CH*WIDTH-1:0] out_data;
    logic [CNT_W-1:0]      bcast_cnt;
    logic [CNT_W-1:0]      drop_cnt;

    // Producer/consumer side (testbench or surrounding logic)
    modport master (
        output in_valid, in1, in2, in3, in4, ch_en, out_ready,
        input  in_ready, out_valid, out_data, bcast_cnt, drop_cnt
    );

    // Pipeline side
    modport slave (
        input  in_valid, in1, in2, in3, in4, ch_en, out_ready,
        output in_ready, out_valid, out_data, bcast_cnt, drop_cnt
    );
endinterface
`default_nettype wire

// File: rtl/search_fanout_pipe_stage.sv
`default_nettype none
// ============================================================================
//  Module   : search_fanout_stage
//  Purpose  : One {valid, data} pipeline register with synchronous reset and
//             shift enable.
//  Revision : 1.0 - initial release
// ============================================================================
module search_fanout_stage #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             en_i,
    input  wire logic             valid_i,
    input  wire logic [WIDTH-1:0] data_i,
    output logic                  valid_o,
    output logic [WIDTH-1:0]      data_o
);
    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    // Shift on enable; an invalid slot still moves so bubbles propagate.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (en_i) begin
            valid_q <= valid_i;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
endmodule
`default_nettype wire

// File: rtl/search_fanout_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : search_fanout_pipe
//  Purpose  : Combines four operands, pipelines the result through STAGES
//             registers and broadcasts it to N_CH handshaked channels.
//  Revision : 1.0 - initial release
// ============================================================================
module search_fanout_pipe
    import search_fanout_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES,
    parameter int N_CH   = DEF_N_CH,
    parameter int INVERT = 0,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  wire logic          clk,
    input  wire logic          rst,
    search_fanout_pipe_if.slave bus
);
    logic [WIDTH-1:0]             w_comb;
    logic [STAGES:0]              w_valid_chain;
    logic [STAGES:0][WIDTH-1:0]   w_data_chain;
    logic                         w_free;
    logic                         w_advance;
    logic                         w_last_valid;
    logic [WIDTH-1:0]             w_last_data;

    logic [N_CH-1:0]  pend_q,  pend_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [CNT_W-1:0] bcast_q, bcast_d;
    logic [CNT_W-1:0] drop_q,  drop_d;

    // Operand combine, bit by bit
    for (genvar b = 0; b < WIDTH; b++) begin : g_comb
        assign w_comb[b] = combine(bus.in1[b], bus.in2[b], bus.in3[b],
                                   bus.in4[b], (INVERT != 0));
    end

    // Stage 0 sees in_valid directly: with in_ready == advance, a shift
    // captures an operand exactly when in_valid & in_ready.
    assign w_valid_chain[0] = bus.in_valid;
    assign w_data_chain[0]  = w_comb;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        search_fanout_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .en_i    (w_advance),
            .valid_i (w_valid_chain[s]),
            .data_i  (w_data_chain[s]),
            .valid_o (w_valid_chain[s+1]),
            .data_o  (w_data_chain[s+1])
        );
    end

    assign w_last_valid = w_valid_chain[STAGES];
    assign w_last_data  = w_data_chain[STAGES];

    // The broadcast register is free once every still-pending channel is
    // accepting this cycle, which allows reload in the same cycle.
    assign w_free    = ((pend_q & ~bus.out_ready) == '0);
    assign w_advance = w_free;

    // Pending mask, broadcast word and counter next-state
    always_comb begin
        pend_d  = pend_q & ~bus.out_ready;
        data_d  = data_q;
        bcast_d = bcast_q;
        drop_d  = drop_q;
        if ((pend_q != '0) && w_free) begin
            bcast_d = bcast_q + CNT_W'(1);
        end
        if (w_advance) begin
            if (w_last_valid) begin
                data_d = w_last_data;
                pend_d = bus.ch_en;
                if (bus.ch_en == '0) begin
                    drop_d = drop_q + CNT_W'(1);
                end
            end else begin
                pend_d = '0;
            end
        end
    end

    // Broadcast register and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q  <= '0;
            data_q  <= '0;
            bcast_q <= '0;
            drop_q  <= '0;
        end else begin
            pend_q  <= pend_d;
            data_q  <= data_d;
            bcast_q <= bcast_d;
            drop_q  <= drop_d;
        end
    end

    assign bus.in_ready  = w_advance;
    assign bus.out_valid = pend_q;
    assign bus.out_data  = {N_CH{data_q}};
    assign bus.bcast_cnt = bcast_q;
    assign bus.drop_cnt  = drop_q;
endmodule
`default_nettype wire
